ld_updown_counter_np: RTL

- Parametrised successor to the fixed 4-bit loadable carry-chain counter cells.
- N-bit synchronous up/down counter with parallel load, clock enable, carry-in and carry-out for cascading, and a programmable terminal value (modulo).
- Adds a registered wrap strobe.
- Used as a prescaler and timebase element and as a cascadable counter slice in the ovi_ec library.

---
 rtl/ld_cnt_pkg.sv | 68 ++++++
 rtl/ld_updown_counter_np_if.sv | 29 ++
 rtl/ld_cnt_tc.sv | 26 ++
 rtl/ld_updown_counter_np.sv | 90 +++++++++
 4 files changed

// File: rtl/ld_cnt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ld_cnt_pkg                                                    |
// | Brief    : Shared constants and next-value helper for ld counter slices. |
// |            Honours LD_UPDOWN_COUNTER_SAT_EN (saturating count).          |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package ld_cnt_pkg;

  localparam logic CNT_DN = 1'b0;
  localparam logic CNT_UP = 1'b1;

  localparam int CNT_MAX_W = 32;

  typedef struct packed {
    logic                 wrap;
    logic [CNT_MAX_W-1:0] val;
  } cnt_res_t;

  // Values are carried at the widest legal width; q never exceeds max, so
  // q+1 is only formed when it still fits.
  function automatic cnt_res_t cnt_next(input logic [CNT_MAX_W-1:0] q,
                                        input logic                 up,
                                        input logic [CNT_MAX_W-1:0] max);
    cnt_res_t r;
    r.wrap = 1'b0;
    r.val  = q;
    if (up == CNT_UP) begin
      if (q == max) begin
`ifndef LD_UPDOWN_COUNTER_SAT_EN
        r.val  = '0;
        r.wrap = 1'b1;
`endif
      end else begin
        r.val = q + 32'd1;
`ifdef LD_UPDOWN_COUNTER_SAT_EN
        r.wrap = (r.val == max);
`endif
      end
    end else begin
      if (q == '0) begin
`ifndef LD_UPDOWN_COUNTER_SAT_EN
        r.val  = max;
        r.wrap = 1'b1;
`endif
      end else begin
        r.val = q - 32'd1;
`ifdef LD_UPDOWN_COUNTER_SAT_EN
        r.wrap = (r.val == '0);
`endif
      end
    end
    return r;
  endfunction

  function automatic bit params_ok(input int              width,
                                   input longint unsigned max_val,
                                   input longint unsigned init_val);
    bit ok;
    ok = (width >= 2) && (width <= CNT_MAX_W);
    if (ok) begin
      ok = (max_val < (64'd1 << width)) && (init_val <= max_val);
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ld_updown_counter_np_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ld_updown_counter_np_if                                       |
// | Brief    : Control/data bundle of one up/down counter slice.             |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface ld_updown_counter_np_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] D;
  logic             SD;
  logic             SP;
  logic             CI;
  logic             UP;
  logic [WIDTH-1:0] Q;
  logic             CO;
  logic             WRAP;

  modport master (
    output D, SD, SP, CI, UP,
    input  Q, CO, WRAP
  );

  modport slave (
    input  D, SD, SP, CI, UP,
    output Q, CO, WRAP
  );
endinterface
`default_nettype wire

// File: rtl/ld_cnt_tc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ld_cnt_tc                                                     |
// | Brief    : Terminal-count comparator; flags both limits and forms CO.    |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module ld_cnt_tc
  import ld_cnt_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  wire logic [WIDTH-1:0] i_q,
  input  wire logic             i_ci,
  input  wire logic             i_up,
  output logic                  o_at_max,
  output logic                  o_at_zero,
  output logic                  o_co
);

  assign o_at_max  = (i_q == MAX_VAL);
  assign o_at_zero = (i_q == '0);
  assign o_co      = i_ci & ((i_up == CNT_UP) ? o_at_max : o_at_zero);

endmodule
`default_nettype wire

// File: rtl/ld_updown_counter_np.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ld_updown_counter_np                                          |
// | Brief    : Loadable modulo up/down counter slice with cascade carry and  |
// |            registered wrap strobe. LD_UPDOWN_COUNTER_SAT_EN: saturate.  |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module ld_updown_counter_np
  import ld_cnt_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned INIT_VAL = (64'd1 << WIDTH) - 64'd1
) (
  input  wire logic             CK,
  input  wire logic             RSTN,
  ld_updown_counter_np_if.slave bus
);

  localparam logic [WIDTH-1:0]     c_max   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0]     c_init  = WIDTH'(INIT_VAL);
  localparam logic [CNT_MAX_W-1:0] c_max32 = CNT_MAX_W'(MAX_VAL);

  generate
    if (!params_ok(WIDTH, MAX_VAL, INIT_VAL)) begin : g_param_check
      $error("ld_updown_counter_np: illegal WIDTH/MAX_VAL/INIT_VAL");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] w_d_clamped;
  logic [WIDTH-1:0] w_cnt_q;
  cnt_res_t         w_res;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_co;
  logic             w_tc_unused;

  assign w_res       = cnt_next(CNT_MAX_W'(r_q), bus.UP, c_max32);
  assign w_cnt_q     = WIDTH'(w_res.val);
  assign w_d_clamped = (bus.D > c_max) ? c_max : bus.D;

  // Priority: hold (SP low) > load > count; WRAP only survives a counting edge.
  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (!bus.SP) begin
      w_q_nxt = r_q;
    end else if (bus.SD) begin
      w_q_nxt = w_d_clamped;
    end else if (bus.CI) begin
      w_q_nxt    = w_cnt_q;
      w_wrap_nxt = w_res.wrap;
    end
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      r_q    <= c_init;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  ld_cnt_tc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (c_max)
  ) u_tc (
    .i_q       (r_q),
    .i_ci      (bus.CI),
    .i_up      (bus.UP),
    .o_at_max  (w_at_max),
    .o_at_zero (w_at_zero),
    .o_co      (w_co)
  );

  // Limit flags are for other users of the comparator; CO is all we need.
  assign w_tc_unused = w_at_max ^ w_at_zero;

  assign bus.Q    = r_q;
  assign bus.WRAP = r_wrap;
  assign bus.CO   = w_co;

endmodule
`default_nettype wire
